keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 214 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row debounce, key encode; optional auto-repeat under KEY_REPEAT_EN.
// flag rises/falls DEBOUNCE_TICKS scan ticks after the detecting / first-released sample; no backpressure (level output).
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_PERIOD  = 150
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       flag
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_PRESS = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_REL   = CW'(DEBOUNCE_TICKS);

  if (SCAN_DIV < 2) begin : g_bad_div
    $error("keypad_scanner: SCAN_DIV must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_deb
    $error("keypad_scanner: DEBOUNCE_TICKS must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_rdly
    $error("keypad_scanner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_rper
    $error("keypad_scanner: REPEAT_PERIOD must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t          state;
  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [DW-1:0]   div;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [1:0]      row_idx;
  logic [1:0]      col_idx;
  logic            any_low;
  logic            sel_low;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_first;
  logic [RW-1:0] rep_lim;

  assign rep_lim = rep_first ? REP_FIRST : REP_NEXT;
`endif

  function automatic logic [1:0] low_row(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[2]) idx = 2'd2;
    if (!r[1]) idx = 2'd1;
    if (!r[0]) idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'ha;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hb;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hc;
      4'b11_00: code = 4'he;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hf;
      4'b11_11: code = 4'hd;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (div == DIV_MAX) begin
      div <= '0;
    end else begin
      div <= div + DW'(1);
    end
  end

  assign tick    = (div == DIV_MAX);
  assign any_low = ~&row_sync;
  assign sel_low = ~row_sync[row_idx];

  // col_idx doubles as the latched column: it only moves while in SCAN or on leaving DEBOUNCE/RELEASE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_SCAN;
      col     <= 4'b1110;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      cnt     <= '0;
      key     <= 4'h0;
      flag    <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt   <= '0;
      rep_first <= 1'b1;
`endif
    end else if (tick) begin
      case (state)
        ST_SCAN: begin
          if (any_low) begin
            row_idx <= low_row(row_sync);
            cnt     <= '0;
            state   <= ST_DEBOUNCE;
          end else begin
            col     <= {col[2:0], col[3]};
            col_idx <= col_idx + 2'd1;
          end
        end

        ST_DEBOUNCE: begin
          if (sel_low) begin
            if (cnt == CNT_PRESS) begin
              state <= ST_HELD;
              key   <= key_code(row_idx, col_idx);
              flag  <= 1'b1;
`ifdef KEY_REPEAT_EN
              rep_cnt   <= '0;
              rep_first <= 1'b1;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
            state   <= ST_SCAN;
            col     <= {col[2:0], col[3]};
            col_idx <= col_idx + 2'd1;
          end
        end

        ST_HELD: begin
          if (!sel_low) begin
            state <= ST_RELEASE;
            cnt   <= CW'(1);
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (rep_cnt == rep_lim) begin
            // one-tick dip gives the consumer a fresh rising edge
            flag      <= 1'b0;
            rep_cnt   <= '0;
            rep_first <= 1'b0;
          end else begin
            flag    <= 1'b1;
            rep_cnt <= rep_cnt + RW'(1);
          end
`endif
        end

        ST_RELEASE: begin
          if (sel_low) begin
            state <= ST_HELD;
            flag  <= 1'b1;
          end else if (cnt == CNT_REL) begin
            // first released sample counted as 1, so the fall lags that sample by DEBOUNCE_TICKS ticks
            state   <= ST_SCAN;
            flag    <= 1'b0;
            col     <= {col[2:0], col[3]};
            col_idx <= col_idx + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 keypad driving row from col.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       flag;
  logic [15:0] pressed;

  int total;
  int bad;

  keypad_scanner #(
    .SCAN_DIV(4),
    .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY(5),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .row (row),
    .col (col),
    .key (key),
    .flag(flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && col[c] == 1'b0) row[r] = 1'b0;
  end

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_flag(input string name, input logic lvl, input int budget, output int n);
    n = 0;
    while (flag !== lvl && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, flag}, {31'd0, lvl});
  endtask

  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    while (col !== want && n < 8) begin
      tick();
      n++;
    end
    chk("wait_col", {28'd0, col}, {28'd0, want});
  endtask

  function automatic logic rep_flag(input int k);
`ifdef KEY_REPEAT_EN
    return !(k >= 5 && ((k - 5) % 3) == 0);
`else
    return (k >= 0);
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [4];
    int n;

    total = 0;
    bad   = 0;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;

    vecs[0]  = '{16'h0001, 4'h1};
    vecs[1]  = '{16'h0008, 4'ha};
    vecs[2]  = '{16'h0020, 4'h5};
    vecs[3]  = '{16'h0400, 4'h9};
    vecs[4]  = '{16'h1000, 4'he};
    vecs[5]  = '{16'h2000, 4'h0};
    vecs[6]  = '{16'h4000, 4'hf};
    vecs[7]  = '{16'h8000, 4'hd};
    vecs[8]  = '{16'h0080, 4'hb};
    vecs[9]  = '{16'h0100, 4'h7};
    vecs[10] = '{16'h0101, 4'h1};
    vecs[11] = '{16'h4040, 4'h6};

    pressed = 16'h0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_col",  {28'd0, col}, 32'he);
    chk("rst_flag", {31'd0, flag}, 32'd0);
    chk("rst_key",  {28'd0, key}, 32'd0);
    rst = 1'b0;

    // idle rotation, one column step every 4 clks
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      chk("idle_col", {28'd0, col}, {28'd0, seq[(k/4)%4]});
      chk("idle_flag", {31'd0, flag}, 32'd0);
    end

    // 'd' on column 3: exact press and release latency
    wait_col(4'b0111);
    pressed = 16'h8000;
    tick();
    chk("d_det_col",  {28'd0, col}, 32'h7);
    chk("d_det_flag", {31'd0, flag}, 32'd0);
    tick();
    tick();
    chk("d_t3_flag", {31'd0, flag}, 32'd0);
    tick();
    chk("d_rise_flag", {31'd0, flag}, 32'd1);
    chk("d_rise_key",  {28'd0, key}, 32'hd);
    for (int t = 5; t <= 20; t++) begin
      tick();
      chk("d_hold_flag", {31'd0, flag}, {31'd0, rep_flag(t - 4)});
      chk("d_hold_col",  {28'd0, col}, 32'h7);
    end
    pressed = 16'h0;
    tick();
    tick();
    tick();
    chk("d_rel3_flag", {31'd0, flag}, 32'd1);
    tick();
    chk("d_fall_flag", {31'd0, flag}, 32'd0);
    chk("d_fall_key",  {28'd0, key}, 32'hd);
    chk("d_fall_col",  {28'd0, col}, 32'he);

    // two-tick glitch on row 0 / column 0
    wait_col(4'b1110);
    pressed = 16'h0001;
    tick();
    chk("gl_col1", {28'd0, col}, 32'he);
    chk("gl_flag1", {31'd0, flag}, 32'd0);
    tick();
    chk("gl_flag2", {31'd0, flag}, 32'd0);
    pressed = 16'h0;
    tick();
    chk("gl_col3", {28'd0, col}, 32'hd);
    chk("gl_flag3", {31'd0, flag}, 32'd0);
    tick();
    chk("gl_col4", {28'd0, col}, 32'hb);

    // key map table
    for (int i = 0; i < 12; i++) begin
      pressed = vecs[i].mask;
      wait_flag("tab_rise", 1'b1, 40, n);
      chk("tab_key", {28'd0, key}, {28'd0, vecs[i].exp_key});
      pressed = 16'h0;
      wait_flag("tab_fall", 1'b0, 10, n);
      chk("tab_fall_ticks", n, 32'd4);
      chk("tab_key_kept", {28'd0, key}, {28'd0, vecs[i].exp_key});
    end

    // rows 0 and 2 on column 0, then a one-tick release bounce
    pressed = 16'h0101;
    wait_flag("bn_rise", 1'b1, 40, n);
    chk("bn_key", {28'd0, key}, 32'h1);
    pressed = 16'h0;
    tick();
    pressed = 16'h0101;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("bn_flag", {31'd0, flag}, 32'd1);
    end
    pressed = 16'h0;
    wait_flag("bn_fall", 1'b0, 10, n);
    chk("bn_fall_ticks", n, 32'd4);

    // reset while '#' is held
    pressed = 16'h4000;
    wait_flag("rs_rise", 1'b1, 40, n);
    chk("rs_key_pre", {28'd0, key}, 32'hf);
    rst = 1'b1;
    #1;
    chk("rs_flag", {31'd0, flag}, 32'd0);
    chk("rs_col",  {28'd0, col}, 32'he);
    chk("rs_key",  {28'd0, key}, 32'h0);
    rst = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      chk("rs_wait_flag", {31'd0, flag}, 32'd0);
    end
    tick();
    chk("rs_redet_flag", {31'd0, flag}, 32'd1);
    chk("rs_redet_key",  {28'd0, key}, 32'hf);
    pressed = 16'h0;
    wait_flag("rs_fall", 1'b0, 10, n);
    chk("rs_fall_ticks", n, 32'd4);

    // '*' held 15 ticks after rise: repeat dips only when the feature is built in
    pressed = 16'h1000;
    wait_flag("st_rise", 1'b1, 40, n);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("st_flag", {31'd0, flag}, {31'd0, rep_flag(k)});
      chk("st_key",  {28'd0, key}, 32'he);
    end
    pressed = 16'h0;
    wait_flag("st_fall", 1'b0, 10, n);
    chk("st_fall_ticks", n, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
